// File: rtl/pc_sequencer.sv
// Program-counter controller for the DLX fetch stage. It owns the PC, drives the
// external fetch adder's operands, and arbitrates start/halt/stall/jump/branch.
module pc_sequencer #(
  parameter int unsigned     width        = 10,
  parameter logic [width-1:0] reset_vector = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt,
  input  logic             stall,
  input  logic             jump,
  input  logic [width-1:0] jump_target,
  input  logic             branch_taken,
  input  logic [width-1:0] branch_base,
  input  logic [width-1:0] branch_offset,
  output logic [width-1:0] adder_a,
  output logic [width-1:0] adder_b,
  input  logic [width-1:0] adder_sum,
  output logic [width-1:0] pc,
  output logic             pc_valid,
  output logic             flush,
  output logic [1:0]       state
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] STALL = 2'b10;
  localparam logic [1:0] HALT  = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [width-1:0] pc_q, pc_d;
  logic             pc_valid_q, pc_valid_d;
  logic             flush_q, flush_d;

  // Requests are only honoured in RUN/STALL; halt beats every redirect.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush_d = 1'b0;
    adder_a = '0;
    adder_b = '0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (branch_taken) begin
          adder_a = branch_base;
          adder_b = branch_offset;
        end else begin
          adder_a = pc_q;
          adder_b = {{(width-1){1'b0}}, 1'b1};
        end
        if (halt) begin
          state_d = HALT;
        end else if (jump) begin
          pc_d    = jump_target;
          flush_d = 1'b1;
        end else if (branch_taken) begin
          pc_d    = adder_sum;
          flush_d = 1'b1;
        end else if (stall) begin
          state_d = STALL;
        end else begin
          pc_d = adder_sum;
        end
      end
      STALL: begin
        if (branch_taken) begin
          adder_a = branch_base;
          adder_b = branch_offset;
        end
        if (halt) begin
          state_d = HALT;
        end else if (jump) begin
          pc_d    = jump_target;
          flush_d = 1'b1;
          state_d = RUN;
        end else if (branch_taken) begin
          pc_d    = adder_sum;
          flush_d = 1'b1;
          state_d = RUN;
        end else if (!stall) begin
          // Resume without incrementing; the held PC is fetched once in RUN.
          state_d = RUN;
        end
      end
      default: ;
    endcase
    pc_valid_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= reset_vector;
      pc_valid_q <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      flush_q    <= flush_d;
    end
  end

  assign state    = state_q;
  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;
  assign flush    = flush_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter controller for the instruction-fetch stage of the MIPS-DLX pipeline. Owns the PC register and sequences the fetch-stage adder: it drives the adder operands each cycle (PC + 1 for sequential fetch, branch base + offset for a taken branch) and registers the selected next PC. It arbitrates between start, halt, stall, jump and branch requests from later pipeline stages, and flags redirects so the fetch/decode registers can be flushed.

## Interface
- `width`, 10: PC and address width in bits.
- `reset_vector`, 0: PC value loaded on reset.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous reset, active low.
- `start`  in  1  leave IDLE and begin fetching.
- `halt`  in  1  stop fetching permanently (until reset).
- `stall`  in  1  hold PC this cycle.
- `jump`  in  1  absolute redirect request.
- `jump_target`  in  width  absolute jump address.
- `branch_taken`  in  1  relative redirect request.
- `branch_base`  in  width  PC of the branch instruction.
- `branch_offset`  in  width  offset, already sign-extended to `width`.
- `adder_a`  out  width  operand A to the fetch adder.
- `adder_b`  out  width  operand B to the fetch adder.
- `adder_sum`  in  width  adder result, combinational, same cycle.
- `pc`  out  width  current fetch address (registered).
- `pc_valid`  out  1  `pc` is a live fetch address.
- `flush`  out  1  one-cycle pulse after an accepted redirect.
- `state`  out  2  FSM state, for debug.

## Operation
- FSM encoding: IDLE=00, RUN=01, STALL=10, HALT=11.
- Request priority each cycle: halt > jump > branch_taken > stall > sequential.
- Request inputs are sampled only in RUN and STALL. IDLE samples only `start`. HALT ignores all inputs.
- Adder operand drive (combinational):
  - RUN/STALL with `branch_taken`: `adder_a`=`branch_base`, `adder_b`=`branch_offset`.
  - RUN otherwise: `adder_a`=`pc`, `adder_b`=1.
  - IDLE, HALT, and STALL without a branch: both operands 0.
  - Operands are a don't-care when jump or halt wins, but must still follow the rules above.
- Transitions:
  - IDLE: `start` goes to RUN and `pc` is unchanged (first fetch is `reset_vector`). Otherwise stay in IDLE.
  - RUN:
    - halt: go to HALT, pc held.
    - jump: `pc`<=`jump_target`, stay in RUN.
    - branch: `pc`<=`adder_sum`, stay in RUN.
    - stall: go to STALL, pc held.
    - else: `pc`<=`adder_sum` (pc+1).
  - STALL:
    - halt: go to HALT.
    - jump or branch: load the target as in RUN and go to RUN.
    - stall still high: stay, pc held.
    - stall low: go to RUN with pc held (the increment resumes in the next RUN cycle).
  - HALT: sticky; only `rst_n` leaves it.
- Redirect overrides stall: a redirect that arrives together with stall is accepted.
- Arithmetic is modulo 2^width. Wrap-around is silent: pc 2^width−1 increments to 0. No overflow flag.
- `pc_valid` = (state==RUN), registered with the state.
- `flush` is registered: 1 for exactly the one cycle after a jump or branch is accepted. Back-to-back redirects keep it high.

## Timing
- Reset (async assert, sync release):
  - `pc`=`reset_vector`, `state`=IDLE.
  - `pc_valid`=0, `flush`=0, `adder_a`=0, `adder_b`=0.
- Reset asserted mid-operation returns the block to IDLE immediately, regardless of state. Pending requests are discarded.
- Latency:
  - Redirect request at edge N: `pc`=target and `flush`=1 after edge N.
  - `start` at edge N: `pc_valid`=1 after edge N.
- One adder evaluation per cycle. The adder path is combinational, so the `pc`→`adder_a`→`adder_sum`→`pc` loop is the critical path.

## Test plan
- Reset then `start`: `pc_valid` rises one cycle after `start`; `pc` reads 0,1,2,3 on consecutive cycles; `flush`=0 throughout.
- `stall` held 3 cycles at pc=5: state=STALL, `pc` stays 5 for 3 cycles. After release: one RUN cycle at 5, then 6.
- Branch with `branch_base`=8, `branch_offset`=0x3FC (−4, width 10) while stalled: `pc`=4 next cycle, state=RUN, `flush`=1 for one cycle, and the adder operands match the branch inputs in the request cycle.
- `jump`=1 (target 0x100) together with `branch_taken`=1 (base 2, offset 3): `pc`=0x100 next cycle, not 5.
- Wrap: pc=0x3FF in RUN, no request: `pc`=0x000 next cycle, `pc_valid` stays 1.
- `halt` together with `jump`: state=HALT, `pc` held, `pc_valid`=0, no `flush`. Later `start`/`jump` are ignored. Asserting `rst_n`=0 mid-HALT returns `pc`=`reset_vector` and state=IDLE asynchronously, before the next clock edge.
